// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// mmio_uart_tx : memory-mapped 8N1 UART transmitter with a TX byte FIFO
// Revision 1.0
// ============================================================================

package mmio_uart_pkg;
  localparam int XLEN = 32;

  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] value;
    logic [1:0]      width;
    logic            enable;
  } mem_write_control_t;
endpackage

module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h0001_0000,
  parameter int          FIFO_DEPTH      = 8,
  parameter int          DEFAULT_DIVISOR = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  mem_write_control_t memory_mapped_io_control,
  output logic [XLEN-1:0]    memory_mapped_io_r_data,
  output logic               memory_mapped_io_write_complete,
  output logic               tx,
  output logic               busy
);

  localparam int          PTR_W         = $clog2(FIFO_DEPTH) + 1;
  localparam int          IDX_W         = PTR_W - 1;
  localparam logic [15:0] RESET_DIVISOR = (DEFAULT_DIVISOR == 0) ? 16'd1 : 16'(DEFAULT_DIVISOR);

  localparam logic [1:0] SEL_TXDATA  = 2'd0;
  localparam logic [1:0] SEL_STATUS  = 2'd1;
  localparam logic [1:0] SEL_DIVISOR = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state_q;
  logic [7:0]       shift_q;
  logic [2:0]       bit_q;
  logic [15:0]      baud_q;
  logic             tx_q;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]       fifo_mem_q [FIFO_DEPTH];
  logic [15:0]      divisor_q, divisor_d;
  logic             armed_q, armed_d;
  logic             write_complete_q;

  logic             in_window;
  logic [1:0]       reg_sel;
  logic             accept;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [PTR_W-1:0] occupancy;
  logic [31:0]      occ_ext;
  logic [3:0]       occ_sat;
  logic [15:0]      div_wdata;
  logic             unused_ctrl_bits;

  assign unused_ctrl_bits = ^{memory_mapped_io_control.value[31:16],
                              memory_mapped_io_control.addr[1:0]};

  // ---------------------------------------------------------------------------
  // Address decode and write handshake
  // ---------------------------------------------------------------------------
  assign in_window = (memory_mapped_io_control.addr[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
  assign reg_sel   = memory_mapped_io_control.addr[3:2];

  // A TXDATA write against a full FIFO is held off rather than dropped.
  assign accept = memory_mapped_io_control.enable && in_window && armed_q &&
                  !((reg_sel == SEL_TXDATA) && fifo_full);
  assign push   = accept && (reg_sel == SEL_TXDATA);
  assign pop    = (state_q == S_IDLE) && !fifo_empty;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                      (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign occupancy  = wr_ptr_q - rd_ptr_q;
  assign occ_ext    = 32'(occupancy);
  assign occ_sat    = (occ_ext > 32'd15) ? 4'hF : occ_ext[3:0];

  assign div_wdata = (memory_mapped_io_control.width == WIDTH_BYTE)
                   ? {8'h00, memory_mapped_io_control.value[7:0]}
                   : memory_mapped_io_control.value[15:0];

  always_comb begin
    wr_ptr_d  = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d  = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    divisor_d = divisor_q;
    if (accept && (reg_sel == SEL_DIVISOR)) begin
      divisor_d = (div_wdata == 16'd0) ? 16'd1 : div_wdata;
    end
    // Re-arm only after the hart drops enable, so a held request acks once.
    if (!memory_mapped_io_control.enable) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q && !accept;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      divisor_q        <= RESET_DIVISOR;
      armed_q          <= 1'b1;
      write_complete_q <= 1'b0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      divisor_q        <= divisor_d;
      armed_q          <= armed_d;
      write_complete_q <= accept;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q[IDX_W-1:0]] <= memory_mapped_io_control.value[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser: the divisor is re-sampled at every bit boundary
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            shift_q <= fifo_mem_q[rd_ptr_q[IDX_W-1:0]];
            baud_q  <= divisor_q - 16'd1;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_q == 16'd0) begin
            state_q <= S_DATA;
            bit_q   <= 3'd0;
            baud_q  <= divisor_q - 16'd1;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        S_DATA: begin
          if (baud_q == 16'd0) begin
            baud_q <= divisor_q - 16'd1;
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        S_STOP: begin
          if (baud_q == 16'd0) begin
            state_q <= S_IDLE;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs and side-effect-free read path
  // ---------------------------------------------------------------------------
  assign tx                              = tx_q;
  assign busy                            = !fifo_empty || (state_q != S_IDLE);
  assign memory_mapped_io_write_complete = write_complete_q;

  always_comb begin
    memory_mapped_io_r_data = '0;
    if (in_window) begin
      case (reg_sel)
        SEL_STATUS: begin
          memory_mapped_io_r_data[0]   = fifo_full;
          memory_mapped_io_r_data[1]   = fifo_empty;
          memory_mapped_io_r_data[2]   = busy;
          memory_mapped_io_r_data[7:4] = occ_sat;
        end
        SEL_DIVISOR: memory_mapped_io_r_data[15:0] = divisor_q;
        default:     memory_mapped_io_r_data = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_mmio_uart_tx : self-checking bench with a line-level UART receiver model
// Revision 1.0
// ============================================================================

module tb_mmio_uart_tx;
  import mmio_uart_pkg::*;

  localparam logic [31:0] BASE     = 32'h0001_0000;
  localparam logic [31:0] A_TXDATA = BASE;
  localparam logic [31:0] A_STATUS = BASE + 32'h4;
  localparam logic [31:0] A_DIV    = BASE + 32'h8;
  localparam logic [31:0] A_RSVD   = BASE + 32'hC;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  mem_write_control_t ctl   = '0;
  logic [31:0]        r_data;
  logic               write_complete;
  logic               tx;
  logic               busy;

  int errors  = 0;
  int checks  = 0;
  int cur_div = 16;
  int mon_frame_errs = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  mmio_uart_tx #(
    .BASE_ADDR      (BASE),
    .FIFO_DEPTH     (8),
    .DEFAULT_DIVISOR(16)
  ) dut (
    .clock                          (clock),
    .reset                          (reset),
    .memory_mapped_io_control       (ctl),
    .memory_mapped_io_r_data        (r_data),
    .memory_mapped_io_write_complete(write_complete),
    .tx                             (tx),
    .busy                           (busy)
  );

  always #5 clock = ~clock;

  // Receiver model: bit k of a frame is centred at k*d + d/2 cycles after the start edge.
  function automatic int bit_slot(input int off, input int d);
    if (off < d / 2) return -1;
    if (((off - d / 2) % d) != 0) return -1;
    return (off - d / 2) / d;
  endfunction

  logic       mon_active = 1'b0;
  int         mon_off    = 0;
  int         mon_div    = 1;
  logic [7:0] mon_sh     = '0;

  always @(negedge clock or negedge reset) begin
    if (!reset) begin
      mon_active <= 1'b0;
    end else if (!mon_active) begin
      if (tx == 1'b0) begin
        mon_active <= 1'b1;
        mon_off    <= 1;
        mon_div    <= cur_div;
      end
    end else begin
      mon_off <= mon_off + 1;
      if (bit_slot(mon_off, mon_div) == 0) begin
        if (tx !== 1'b0) mon_frame_errs <= mon_frame_errs + 1;
      end else if (bit_slot(mon_off, mon_div) >= 1 && bit_slot(mon_off, mon_div) <= 8) begin
        mon_sh <= {tx, mon_sh[7:1]};
      end else if (bit_slot(mon_off, mon_div) == 9) begin
        if (tx !== 1'b1) mon_frame_errs <= mon_frame_errs + 1;
        rx_q.push_back(mon_sh);
        mon_active <= 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // Holds a write request until acknowledged or max_cycles elapse, then releases enable.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] v, input logic [1:0] w,
                           input int max_cycles, output int n, output bit ok);
    ctl.addr = a; ctl.value = v; ctl.width = w; ctl.enable = 1'b1;
    ok = 1'b0; n = 0;
    while (!ok && n < max_cycles) begin
      @(negedge clock); n++;
      if (write_complete === 1'b1) ok = 1'b1;
    end
    ctl.enable = 1'b0;
    @(negedge clock);
  endtask

  task automatic wait_idle(input int max_cycles, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < max_cycles) begin
      @(negedge clock); n++;
      if (busy === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; ctl = '0;
    repeat (3) @(negedge clock);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || write_complete !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: tx=%b busy=%b wc=%b, required 1 0 0", tx, busy, write_complete);
    end
    reset = 1'b1;
    ctl.addr = A_STATUS; @(negedge clock);
    checks++;
    if (r_data !== 32'h2) begin
      errors++; $display("FAIL reset_status: got %h, required 00000002", r_data);
    end
    ctl.addr = A_DIV; @(negedge clock);
    checks++;
    if (r_data !== 32'd16) begin
      errors++; $display("FAIL reset_divisor: got %0d, required 16", r_data);
    end
    ctl.addr = A_TXDATA; @(negedge clock);
    checks++;
    if (r_data !== 32'h0 || tx !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_txdata_read: r=%h tx=%b busy=%b, required 0 1 0", r_data, tx, busy);
    end
    ctl.addr = A_RSVD; @(negedge clock);
    checks++;
    if (r_data !== 32'h0) begin
      errors++; $display("FAIL reset_reserved_read: got %h, required 0", r_data);
    end
    cur_div = 16;
  endtask

  task automatic test_frame();
    int n; bit ok; logic [7:0] data; logic exp_bit;
    data = 8'h41;
    bus_write(A_DIV, 32'd4, WIDTH_WORD, 10, n, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL frame_div_ack: no acknowledge, required one"); end
    cur_div = 4;
    bus_write(A_TXDATA, {24'h0, data}, WIDTH_WORD, 10, n, ok);
    exp_q.push_back(data);
    checks++;
    if (!ok || n != 1) begin
      errors++; $display("FAIL frame_ack_latency: ok=%0d cycles=%0d, required ok=1 cycles=1", ok, n);
    end
    checks++;
    if (write_complete !== 1'b0) begin
      errors++; $display("FAIL frame_ack_width: wc=%b one cycle after ack, required 0", write_complete);
    end
    for (int off = 0; off < 40; off++) begin
      if (off != 0) @(negedge clock);
      exp_bit = (off / 4 == 0) ? 1'b0 : (off / 4 == 9) ? 1'b1 : data[off / 4 - 1];
      checks++;
      if (tx !== exp_bit) begin
        errors++; $display("FAIL frame_tx_cycle%0d: tx=%b, required %b", off, tx, exp_bit);
      end
      if (off == 39) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy_in_stop: busy=%b, required 1", busy); end
      end
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++; $display("FAIL frame_busy_after: busy=%b tx=%b, required 0 1", busy, tx);
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL frame_rx_count: got %0d, required %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL frame_rx_byte%0d: got %h, required %h", i, rx_q[i], exp_q[i]);
      end
    end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_held_enable();
    int acks = 0;
    ctl.addr = A_DIV; ctl.value = 32'h0; ctl.width = WIDTH_WORD; ctl.enable = 1'b1;
    repeat (20) begin
      @(negedge clock);
      if (write_complete === 1'b1) acks++;
    end
    ctl.enable = 1'b0;
    @(negedge clock);
    checks++;
    if (acks != 1) begin errors++; $display("FAIL held_enable_acks: got %0d, required 1", acks); end
    ctl.addr = A_DIV; @(negedge clock);
    checks++;
    if (r_data !== 32'd1) begin errors++; $display("FAIL held_enable_div0: got %0d, required 1", r_data); end
    cur_div = 1;
  endtask

  task automatic test_full_fifo();
    int n; int acks = 0; int fall_idx = -1; bit ok; bit got = 1'b0;
    bus_write(A_DIV, 32'd250, WIDTH_WORD, 10, n, ok);
    cur_div = 250;
    for (int b = 0; b < 9; b++) begin
      bus_write(A_TXDATA, 32'h10 + 32'(b), WIDTH_WORD, 10, n, ok);
      if (ok) begin acks++; exp_q.push_back(8'(8'h10 + b)); end
    end
    checks++;
    if (acks != 9) begin errors++; $display("FAIL full_fill_acks: got %0d, required 9", acks); end
    ctl.addr = A_STATUS; @(negedge clock);
    checks++;
    if (r_data !== 32'h85) begin
      errors++; $display("FAIL full_status: got %h, required 00000085", r_data);
    end
    ctl.addr = A_TXDATA; ctl.value = 32'h19; ctl.width = WIDTH_WORD; ctl.enable = 1'b1;
    n = 0;
    while (!got && n < 4000) begin
      @(negedge clock); n++;
      if (write_complete === 1'b1) got = 1'b1;
      else if (fall_idx < 0 && rx_q.size() >= 1 && tx === 1'b0) fall_idx = n;
    end
    ctl.enable = 1'b0;
    @(negedge clock);
    checks++;
    if (!got || n < 100) begin
      errors++; $display("FAIL full_stall: acked=%0d after %0d cycles, required a long stall then ack", got, n);
    end
    checks++;
    if (n != fall_idx + 1) begin
      errors++; $display("FAIL full_ack_after_pop: ack cycle %0d, required %0d", n, fall_idx + 1);
    end
    if (got) exp_q.push_back(8'h19);
    wait_idle(30000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL full_drain: busy=%b after budget, required 0", busy); end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL full_rx_count: got %0d, required %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL full_rx_byte%0d: got %h, required %h", i, rx_q[i], exp_q[i]);
      end
    end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_divisor_and_window();
    int n; bit ok;
    bus_write(A_DIV, 32'hFFFF_12AB, WIDTH_BYTE, 10, n, ok);
    ctl.addr = A_DIV; @(negedge clock);
    checks++;
    if (!ok || r_data !== 32'h0000_00AB) begin
      errors++; $display("FAIL div_byte: ok=%0d got %h, required ok=1 000000ab", ok, r_data);
    end
    bus_write(A_DIV, 32'hABCD_0007, WIDTH_HALF, 10, n, ok);
    ctl.addr = A_DIV; @(negedge clock);
    checks++;
    if (!ok || r_data !== 32'h0000_0007) begin
      errors++; $display("FAIL div_half: ok=%0d got %h, required ok=1 00000007", ok, r_data);
    end
    cur_div = 7;
    bus_write(32'h0002_0000, 32'h55, WIDTH_WORD, 30, n, ok);
    checks++;
    if (ok) begin errors++; $display("FAIL outside_txdata_ack: acknowledged, required no ack"); end
    bus_write(32'h0002_0008, 32'h3, WIDTH_WORD, 30, n, ok);
    checks++;
    if (ok) begin errors++; $display("FAIL outside_div_ack: acknowledged, required no ack"); end
    ctl.addr = 32'h0002_0008; @(negedge clock);
    checks++;
    if (r_data !== 32'h0) begin errors++; $display("FAIL outside_read: got %h, required 0", r_data); end
    bus_write(A_RSVD, 32'h9, WIDTH_WORD, 10, n, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reserved_ack: no ack, required ack"); end
    ctl.addr = A_DIV; @(negedge clock);
    checks++;
    if (r_data !== 32'd7) begin errors++; $display("FAIL div_unchanged: got %0d, required 7", r_data); end
    ctl.addr = A_STATUS; @(negedge clock);
    checks++;
    if (r_data !== 32'h2 || tx !== 1'b1) begin
      errors++; $display("FAIL window_state_unchanged: status=%h tx=%b, required 00000002 1", r_data, tx);
    end
    bus_write(A_TXDATA + 32'h1, 32'hFFFF_FF5A, WIDTH_BYTE, 10, n, ok);
    if (ok) exp_q.push_back(8'h5A);
    wait_idle(200, ok);
    checks++;
    if (rx_q.size() != 1 || exp_q.size() != 1 || rx_q[0] !== 8'h5A) begin
      errors++; $display("FAIL byte_lane_txdata: rx count %0d, required one byte 5a", rx_q.size());
    end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midframe();
    int n; bit ok;
    bus_write(A_DIV, 32'd8, WIDTH_WORD, 10, n, ok);
    cur_div = 8;
    bus_write(A_TXDATA, 32'h00, WIDTH_WORD, 10, n, ok);
    bus_write(A_TXDATA, 32'h11, WIDTH_WORD, 10, n, ok);
    bus_write(A_TXDATA, 32'h22, WIDTH_WORD, 10, n, ok);
    bus_write(A_TXDATA, 32'h33, WIDTH_WORD, 10, n, ok);
    repeat (20) @(negedge clock);
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL midframe_precondition: tx=%b busy=%b, required 0 1", tx, busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL midframe_async_reset: tx=%b busy=%b, required 1 0", tx, busy);
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    cur_div = 16;
    ctl.addr = A_STATUS; @(negedge clock);
    checks++;
    if (r_data !== 32'h2) begin errors++; $display("FAIL midframe_status: got %h, required 00000002", r_data); end
    repeat (300) @(negedge clock);
    checks++;
    if (rx_q.size() != 0 || tx !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL midframe_no_frames: rx=%0d tx=%b busy=%b, required 0 1 0", rx_q.size(), tx, busy);
    end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int n; bit ok; int div; int nb; logic [31:0] v; logic [1:0] w;
    for (int r = 0; r < 6; r++) begin
      div = $urandom_range(1, 6);
      bus_write(A_DIV, 32'(div), WIDTH_WORD, 10, n, ok);
      cur_div = div;
      ctl.addr = A_DIV; @(negedge clock);
      checks++;
      if (r_data !== 32'(div)) begin
        errors++; $display("FAIL rand_div_r%0d: got %0d, required %0d", r, r_data, div);
      end
      nb = $urandom_range(1, 5);
      for (int b = 0; b < nb; b++) begin
        v = $urandom;
        w = 2'($urandom_range(0, 2));
        bus_write(A_TXDATA + 32'($urandom_range(0, 3)), v, w, 400, n, ok);
        if (ok) exp_q.push_back(v[7:0]);
      end
      wait_idle(2000, ok);
      checks++;
      if (!ok || rx_q.size() != nb || exp_q.size() != nb) begin
        errors++; $display("FAIL rand_count_r%0d: rx=%0d queued=%0d, required %0d", r, rx_q.size(), exp_q.size(), nb);
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand_byte_r%0d_%0d: got %h, required %h", r, i, rx_q[i], exp_q[i]);
        end
      end
      rx_q.delete(); exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_held_enable();
    test_full_fifo();
    test_divisor_and_window();
    test_reset_midframe();
    test_random();
    checks++;
    if (mon_frame_errs != 0) begin
      errors++; $display("FAIL framing: %0d bad start/stop bits, required 0", mon_frame_errs);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
